i2c_senzor_target: RTL and testbench
====================================

// Module: i2c_senzor_target
// PURPOSE
//  I2C target (responder) model of the colour sensor; the other end of the I2C master in the sensor subsystem.
//  - Oversamples SCL/SDA on the system clock.
//  - Matches a 7-bit address and accepts a 1-byte channel command.
//  - Returns 16-bit channel samples (clear/red/green/blue/infrared) as byte pairs, with selectable byte order.
//  - Open-drain style: the block only ever pulls SDA low; it never drives SCL (no clock stretching).
// PARAMETERS
//  TARGET_ADDR  7'h29  7-bit I2C address this target answers to
//  SYNC_STAGES  2      synchronizer depth on scl_in/sda_in (>=2)
// PORTS
//  clk            in   1   system clock; must be >= 8x the SCL frequency
//  rst_n          in   1   asynchronous reset, active low
//  scl_in         in   1   SCL level from pad
//  sda_in         in   1   SDA level from pad
//  sda_oe         out  1   1 = pull SDA low; 0 = release SDA
//  clear_data     in   16  clear channel sample
//  red_data       in   16  red channel sample
//  green_data     in   16  green channel sample
//  blue_data      in   16  blue channel sample
//  infrared_data  in   16  infrared channel sample
//  endian         in   1   0 = LSB byte first; 1 = MSB byte first (sampled at snapshot)
//  data_enable    out  1   1-clk pulse at snapshot; requests new samples from the data source
//  busy           out  1   high from an address-matching START until STOP
//  nack_err       out  1   1-clk pulse when an invalid command byte is NACKed
// BEHAVIOUR
//  Reset values: sda_oe=0, data_enable=0, busy=0, nack_err=0, ptr=0, snapshot=0, state=IDLE.
//  Line synchronization and edge detection
//   - scl_in/sda_in pass through SYNC_STAGES flops, then edge detection.
//   - START = SDA fall while SCL high; STOP = SDA rise while SCL high.
//   - Bits are sampled on the synchronized SCL rise, MSB first.
//   - sda_oe changes only on the clk after a synchronized SCL fall.
//  States: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX, TX_ACK, IGNORE.
//  Transitions
//   - IDLE -> ADDR on START.
//   - ADDR: after 8 bits, go to ADDR_ACK if addr==TARGET_ADDR, else IGNORE.
//   - ADDR_ACK: drive ACK for one SCL period; then CMD if R/W=0, TX if R/W=1.
//   - Read match (R/W=1): snapshot all 5 channels plus endian into registers; pulse data_enable; byte_idx=0.
//   - CMD: 8-bit command.
//     - Value 0..4 (clear, red, green, blue, infrared): ptr <= value; ACK.
//     - Value >4: NACK; pulse nack_err; ptr unchanged.
//     - Either case -> CMD_ACK -> IGNORE. Further written bytes are not ACKed.
//   - TX: shift out the byte selected by ptr/byte_idx/endian.
//     - A '1' bit releases SDA; a '0' bit pulls SDA low.
//     - Pointer order after every 2nd byte: ptr 0->1->2->3->4->0 (wraps).
//   - TX_ACK: release SDA and sample the master's ACK on SCL rise.
//     - ACK -> TX with the next byte.
//     - NACK -> IGNORE.
//  Precedence and boundary rules
//   - START in any state = repeated start -> ADDR; SDA released on the same clk.
//   - STOP in any state -> IDLE; SDA released; busy=0.
//   - START and STOP are only recognized while SCL is high; a data bit must not change while SCL is high.
//   - The snapshot is frozen for the whole read; source changes mid-read are invisible.
//   - Address mismatch: SDA is never driven until the next START or STOP.
//   - Async reset mid-transfer: sda_oe drops to 0 immediately and the FSM goes to IDLE.
//   - Bit and byte counters are 3-bit and 1-bit; overflow into ACK states is explicit, not wrapped.
//  Latency: sda_oe responds 1 clk after the synchronized SCL fall, i.e. SYNC_STAGES+1 clk after the pad edge.
// STRUCTURE
//  senzor_pkg
//   - typedef enum i2c_tgt_state_t (the 8 states above)
//   - typedef enum channel_e {CH_CLEAR=0, CH_RED, CH_GREEN, CH_BLUE, CH_IR}
//   - localparam NUM_CH=5
//  Sub-module i2c_line_sync: synchronizers + edge detection.
//   - Outputs: scl_rise, scl_fall, sda_s, start_det, stop_det.
//  The top level holds the FSM, shift register, counters and snapshot registers.
// TESTING
//  1. Write cmd 0x02, then repeated-start read 4 bytes; green=16'hA55A, blue=16'h1234, endian=0
//     -> bytes 5A,A5,34,12; all ACKs driven; data_enable pulses once.
//  2. Same as 1 with endian=1 -> bytes A5,5A,12,34.
//  3. Address 7'h30 -> no ACK (sda_oe=0 throughout); busy stays 0; next START to 7'h29 is served normally.
//  4. Cmd 0x07 -> NACK on the 9th bit; nack_err pulse; a following read still starts from the previous ptr.
//  5. ptr=4, read 4 bytes with infrared=16'h00FF, clear=16'hBEEF, endian=0 -> FF,00,EF,BE (wrap to clear).
//  6. Master NACKs after byte 1, then STOP -> sda_oe=0, busy=0.
//     Separately, assert rst_n=0 mid-byte -> sda_oe=0 asynchronously and state=IDLE.

Source files
------------

// File: rtl/senzor_pkg.sv
// Shared types and constants for the colour-sensor I2C target.
package senzor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        CMD,
        CMD_ACK,
        TX,
        TX_ACK,
        IGNORE
    } i2c_tgt_state_t;

    typedef enum logic [2:0] {
        CH_CLEAR = 3'd0,
        CH_RED,
        CH_GREEN,
        CH_BLUE,
        CH_IR
    } channel_e;

    localparam int NUM_CH = 5;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the SCL/SDA pad levels into the clk domain and flags
// SCL edges plus START/STOP conditions.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Idle bus is high on both lines, so the pipes reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_in};
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_pipe[SYNC_STAGES-1];
            sda_d    <= sda_pipe[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_pipe[SYNC_STAGES-1];
    assign sda_s     = sda_pipe[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_senzor_target.sv
// Colour-sensor I2C target: address match, channel command byte, and
// frozen-snapshot readout of 16-bit channel samples over open-drain SDA.
module i2c_senzor_target
    import senzor_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h29,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] clear_data,
    input  logic [15:0] red_data,
    input  logic [15:0] green_data,
    input  logic [15:0] blue_data,
    input  logic [15:0] infrared_data,
    input  logic        endian,
    output logic        data_enable,
    output logic        busy,
    output logic        nack_err
);

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_tgt_state_t state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [6:0]     shift_q, shift_d;
    logic [2:0]     ptr_q, ptr_d;
    logic           byte_idx_q, byte_idx_d;
    logic           ack_seen_q, ack_seen_d;
    logic           cmd_ok_q, cmd_ok_d;
    logic           rw_q, rw_d;
    logic           sda_oe_q, sda_oe_d;
    logic           busy_q, busy_d;
    logic           data_enable_q, data_enable_d;
    logic           nack_err_q, nack_err_d;
    logic           snap_load;

    logic [15:0]    snap_q [NUM_CH];
    logic           snap_endian_q;
    logic [15:0]    tx_word;
    logic [7:0]     tx_byte;
    logic [7:0]     cmd_byte;

    assign cmd_byte = {shift_q, sda_s};

    always_comb begin
        case (ptr_q)
            CH_RED:   tx_word = snap_q[1];
            CH_GREEN: tx_word = snap_q[2];
            CH_BLUE:  tx_word = snap_q[3];
            CH_IR:    tx_word = snap_q[4];
            default:  tx_word = snap_q[0];
        endcase
        tx_byte = (byte_idx_q ^ snap_endian_q) ? tx_word[15:8] : tx_word[7:0];
    end

    // The snapshot is taken once per read so the whole transfer sees consistent samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
            snap_endian_q <= 1'b0;
        end else if (snap_load) begin
            snap_q[0]     <= clear_data;
            snap_q[1]     <= red_data;
            snap_q[2]     <= green_data;
            snap_q[3]     <= blue_data;
            snap_q[4]     <= infrared_data;
            snap_endian_q <= endian;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            ptr_q         <= '0;
            byte_idx_q    <= 1'b0;
            ack_seen_q    <= 1'b0;
            cmd_ok_q      <= 1'b0;
            rw_q          <= 1'b0;
            sda_oe_q      <= 1'b0;
            busy_q        <= 1'b0;
            data_enable_q <= 1'b0;
            nack_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            ptr_q         <= ptr_d;
            byte_idx_q    <= byte_idx_d;
            ack_seen_q    <= ack_seen_d;
            cmd_ok_q      <= cmd_ok_d;
            rw_q          <= rw_d;
            sda_oe_q      <= sda_oe_d;
            busy_q        <= busy_d;
            data_enable_q <= data_enable_d;
            nack_err_q    <= nack_err_d;
        end
    end

    // ACK states span two SCL falls: the first one drives the ACK level, the
    // second (after the 9th rise sets ack_seen) hands SDA to the next phase.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        ptr_d         = ptr_q;
        byte_idx_d    = byte_idx_q;
        ack_seen_d    = ack_seen_q;
        cmd_ok_d      = cmd_ok_q;
        rw_d          = rw_q;
        sda_oe_d      = sda_oe_q;
        busy_d        = busy_q;
        data_enable_d = 1'b0;
        nack_err_d    = 1'b0;
        snap_load     = 1'b0;

        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d    = ADDR;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = '0;
            ack_seen_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[5:0], sda_s};
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_q == TARGET_ADDR) begin
                                state_d    = ADDR_ACK;
                                ack_seen_d = 1'b0;
                                rw_d       = sda_s;
                                busy_d     = 1'b1;
                                if (sda_s) begin
                                    snap_load     = 1'b1;
                                    data_enable_d = 1'b1;
                                    byte_idx_d    = 1'b0;
                                end
                            end else begin
                                state_d = IGNORE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise) ack_seen_d = 1'b1;
                    if (scl_fall) begin
                        if (!ack_seen_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            bit_cnt_d = '0;
                            if (rw_q) begin
                                state_d  = TX;
                                sda_oe_d = ~tx_byte[7];
                            end else begin
                                state_d  = CMD;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end
                CMD: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[5:0], sda_s};
                        if (bit_cnt_q == 3'd7) begin
                            state_d    = CMD_ACK;
                            ack_seen_d = 1'b0;
                            if (cmd_byte < 8'(NUM_CH)) begin
                                ptr_d    = cmd_byte[2:0];
                                cmd_ok_d = 1'b1;
                            end else begin
                                cmd_ok_d   = 1'b0;
                                nack_err_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                CMD_ACK: begin
                    if (scl_rise) ack_seen_d = 1'b1;
                    if (scl_fall) begin
                        if (!ack_seen_q) begin
                            sda_oe_d = cmd_ok_q;
                        end else begin
                            state_d  = IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                TX: begin
                    if (scl_fall) sda_oe_d = ~tx_byte[~bit_cnt_q];
                    if (scl_rise) begin
                        if (bit_cnt_q == 3'd7) begin
                            state_d    = TX_ACK;
                            ack_seen_d = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = IGNORE;
                        end else begin
                            ack_seen_d = 1'b1;
                            byte_idx_d = ~byte_idx_q;
                            if (byte_idx_q) begin
                                ptr_d = (ptr_q == 3'(CH_IR)) ? 3'd0 : ptr_q + 3'd1;
                            end
                        end
                    end
                    if (scl_fall) begin
                        if (!ack_seen_q) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            state_d   = TX;
                            bit_cnt_d = '0;
                            sda_oe_d  = ~tx_byte[7];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe      = sda_oe_q;
    assign busy        = busy_q;
    assign data_enable = data_enable_q;
    assign nack_err    = nack_err_q;

endmodule

// File: tb/tb_i2c_senzor_target.sv
// Scoreboard bench for i2c_senzor_target: a bit-banged I2C master issues
// directed and random transactions against a byte-level reference model.
module tb_i2c_senzor_target;

    localparam int Q = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_oe, data_enable, busy, nack_err;
    logic [15:0] clear_data, red_data, green_data, blue_data, infrared_data;
    logic        endian;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_senzor_target dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scl_in        (scl_m),
        .sda_in        (sda_line),
        .sda_oe        (sda_oe),
        .clear_data    (clear_data),
        .red_data      (red_data),
        .green_data    (green_data),
        .blue_data     (blue_data),
        .infrared_data (infrared_data),
        .endian        (endian),
        .data_enable   (data_enable),
        .busy          (busy),
        .nack_err      (nack_err)
    );

    string exp_tag[$];
    int    exp_val[$];
    int    obs_val[$];
    int    vectors = 0;
    int    miscompares = 0;

    int    m_ch[5];
    bit    m_endian;
    int    m_ptr;
    bit    txn_matched;

    int    de_count = 0;
    int    ne_count = 0;
    int    oe_clocks = 0;

    always @(posedge clk) begin
        if (data_enable) de_count <= de_count + 1;
        if (nack_err)    ne_count <= ne_count + 1;
        if (sda_oe)      oe_clocks <= oe_clocks + 1;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor: pairs each observed DUT response with the oldest expectation.
    initial begin : monitor
        int actual;
        forever begin
            @(negedge clk);
            while (obs_val.size() > 0) begin
                actual = obs_val.pop_front();
                if (exp_val.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_obs: got 0x%0h, expected nothing", actual);
                end else begin
                    checkOutput(exp_tag.pop_front(), actual, exp_val.pop_front());
                end
            end
        end
    end

    task automatic expect_val(input string tag, input int v);
        exp_tag.push_back(tag);
        exp_val.push_back(v);
    endtask

    task automatic observe(input int v);
        obs_val.push_back(v);
    endtask

    function automatic int model_byte(input int word, input bit msb_first, input int idx);
        bit take_low;
        take_low = (idx == 0) != msb_first;
        return take_low ? (word & 'hFF) : ((word >> 8) & 'hFF);
    endfunction

    task automatic drive_sources();
        clear_data    = 16'(m_ch[0]);
        red_data      = 16'(m_ch[1]);
        green_data    = 16'(m_ch[2]);
        blue_data     = 16'(m_ch[3]);
        infrared_data = 16'(m_ch[4]);
        endian        = m_endian;
    endtask

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic send_byte(input logic [7:0] data, output bit ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = data[i]; qwait();
            scl_m = 1'b1; qwait(); qwait();
            scl_m = 1'b0; qwait();
        end
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        ack = sda_line; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic recv_byte(input bit master_ack, output logic [7:0] data);
        data = '0;
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; qwait();
            scl_m = 1'b1; qwait();
            data[i] = sda_line; qwait();
            scl_m = 1'b0; qwait();
        end
        sda_m = master_ack ? 1'b0 : 1'b1; qwait();
        scl_m = 1'b1; qwait(); qwait();
        scl_m = 1'b0; qwait();
        sda_m = 1'b1;
    endtask

    task automatic finish_txn();
        bus_stop();
        qwait();
        expect_val("busy_after_stop", 0);   observe(int'(busy));
        expect_val("sda_oe_after_stop", 0); observe(int'(sda_oe));
        txn_matched = 1'b0;
    endtask

    task automatic do_write_cmd(input int addr7, input int cmd, input bit extra, input bit do_stop);
        bit ack;
        bit match;
        int ne0;
        match = (addr7 == 'h29);
        ne0 = ne_count;
        bus_start();
        expect_val("addr_ack_w", match ? 0 : 1);
        send_byte(8'(addr7 << 1), ack); observe(int'(ack));
        if (match) txn_matched = 1'b1;
        expect_val("busy_after_addr_w", int'(txn_matched)); observe(int'(busy));
        expect_val("cmd_ack", (match && cmd < 5) ? 0 : 1);
        send_byte(8'(cmd), ack); observe(int'(ack));
        if (match && cmd < 5) m_ptr = cmd;
        expect_val("nack_err_pulses", (match && cmd >= 5) ? 1 : 0); observe(ne_count - ne0);
        if (extra) begin
            expect_val("extra_byte_ack", 1);
            send_byte(8'($urandom_range(0, 255)), ack); observe(int'(ack));
        end
        if (do_stop) finish_txn();
    endtask

    task automatic do_read(input int addr7, input int nbytes);
        bit          ack;
        bit          match;
        int          de0, oe0;
        int          snap[5];
        bit          snap_end;
        logic [7:0]  rx;
        match = (addr7 == 'h29);
        de0 = de_count;
        oe0 = oe_clocks;
        for (int i = 0; i < 5; i++) snap[i] = m_ch[i];
        snap_end = m_endian;
        bus_start();
        expect_val("addr_ack_r", match ? 0 : 1);
        send_byte(8'((addr7 << 1) | 1), ack); observe(int'(ack));
        if (match) txn_matched = 1'b1;
        expect_val("busy_after_addr_r", int'(txn_matched)); observe(int'(busy));
        // Source changes after the snapshot must not reach the bus.
        for (int i = 0; i < 5; i++) m_ch[i] = $urandom_range(0, 65535);
        m_endian = 1'($urandom_range(0, 1));
        drive_sources();
        for (int i = 0; i < nbytes; i++) begin
            if (match) expect_val("rd_byte", model_byte(snap[m_ptr], snap_end, i % 2));
            else       expect_val("rd_byte_unaddressed", 'hFF);
            recv_byte(i < nbytes - 1, rx); observe(int'(rx));
            if (match && (i % 2 == 1) && (i < nbytes - 1)) m_ptr = (m_ptr + 1) % 5;
        end
        finish_txn();
        expect_val("data_enable_pulses", match ? 1 : 0); observe(de_count - de0);
        if (!match) begin
            expect_val("sda_oe_clocks_unaddressed", 0); observe(oe_clocks - oe0);
        end
    endtask

    task automatic applyStimulus();
        int cmd, waddr, raddr, n;
        for (int i = 0; i < 5; i++) m_ch[i] = $urandom_range(0, 65535);
        m_endian = 1'($urandom_range(0, 1));
        drive_sources();
        cmd   = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 255) : $urandom_range(0, 4);
        waddr = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 127) : 'h29;
        raddr = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 127) : 'h29;
        n     = $urandom_range(1, 6);
        do_write_cmd(waddr, cmd, 1'($urandom_range(0, 1)), 1'b0);
        do_read(raddr, n);
    endtask

    task automatic set_channels(input int c, input int r, input int g, input int b, input int ir, input bit e);
        m_ch[0] = c; m_ch[1] = r; m_ch[2] = g; m_ch[3] = b; m_ch[4] = ir;
        m_endian = e;
        drive_sources();
    endtask

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : main
        bit ack;
        m_ptr = 0;
        txn_matched = 1'b0;
        set_channels(0, 0, 0, 0, 0, 1'b0);
        repeat (5) @(negedge clk);
        expect_val("reset_sda_oe", 0);      observe(int'(sda_oe));
        expect_val("reset_busy", 0);        observe(int'(busy));
        expect_val("reset_data_enable", 0); observe(int'(data_enable));
        expect_val("reset_nack_err", 0);    observe(int'(nack_err));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] directed: command then repeated-start read");
        set_channels('h1111, 'h2222, 'hA55A, 'h1234, 'h3333, 1'b0);
        do_write_cmd('h29, 2, 1'b0, 1'b0);
        do_read('h29, 4);
        set_channels('h1111, 'h2222, 'hA55A, 'h1234, 'h3333, 1'b1);
        do_write_cmd('h29, 2, 1'b0, 1'b0);
        do_read('h29, 4);

        $display("[TB] directed: foreign address then normal read");
        do_read('h30, 2);
        do_write_cmd('h29, 1, 1'b0, 1'b0);
        do_read('h29, 2);

        $display("[TB] directed: invalid command keeps pointer");
        set_channels('h0102, 'h0304, 'h0506, 'h0708, 'h090A, 1'b0);
        do_write_cmd('h29, 3, 1'b0, 1'b1);
        do_write_cmd('h29, 7, 1'b1, 1'b1);
        set_channels('h0102, 'h0304, 'h0506, 'h0708, 'h090A, 1'b0);
        do_read('h29, 2);

        $display("[TB] directed: pointer wrap and early NACK");
        set_channels('hBEEF, 'h2222, 'h3333, 'h4444, 'h00FF, 1'b0);
        do_write_cmd('h29, 4, 1'b0, 1'b0);
        do_read('h29, 4);
        do_write_cmd('h29, 1, 1'b0, 1'b0);
        do_read('h29, 1);

        $display("[TB] directed: async reset mid-byte");
        set_channels('h0000, 'h1111, 'h2222, 'h3333, 'h4444, 1'b0);
        do_write_cmd('h29, 0, 1'b0, 1'b0);
        bus_start();
        expect_val("addr_ack_pre_reset", 0);
        send_byte(8'h53, ack); observe(int'(ack));
        sda_m = 1'b1; qwait();
        expect_val("sda_oe_before_reset", 1); observe(int'(sda_oe));
        #2 rst_n = 1'b0;
        #1;
        expect_val("sda_oe_async_reset", 0); observe(int'(sda_oe));
        expect_val("busy_async_reset", 0);   observe(int'(busy));
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        txn_matched = 1'b0;
        repeat (3) @(negedge clk);
        set_channels('hC0DE, 'h1111, 'h2222, 'h3333, 'h4444, 1'b1);
        do_read('h29, 2);

        $display("[TB] random transactions");
        for (int t = 0; t < 12; t++) applyStimulus();

        repeat (20) @(negedge clk);
        if (exp_val.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL pending_expectations: got %0d left, expected 0", exp_val.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
